// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: timekeeping and time/alarm set controller for the VGA clock.
// Keeps BCD time (and optionally an alarm), steps through set modes from
// debounced button pulses and drives registered digit, mode and blink outputs.
// Alarm support (ALARM_* states, alarm registers, alarm_match) is compiled in
// only when the macro ALARM_CLOCK_EN is defined.
module clock_time_ctrl #(
  parameter int HOUR_24      = 1,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  output logic [3:0] hour_first,
  output logic [3:0] hour_second,
  output logic [3:0] min_first,
  output logic [3:0] min_second,
  output logic [3:0] sec_first,
  output logic [3:0] sec_second,
  output logic [3:0] mode_at,
  output logic [2:0] field_blank,
  output logic       alarm_match
);

  localparam int            CW         = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_CYCLES - 1);
  localparam logic [7:0]    HOUR_RESET = (HOUR_24 != 0) ? 8'h00 : 8'h12;

`ifdef ALARM_CLOCK_EN
  typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_SEC, ALARM_HOUR, ALARM_MIN} state_t;
`else
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    cur_hour, cur_min, cur_sec;
  logic [7:0]    hour_n, min_n, sec_n;
  logic [CW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_hidden, blink_hidden_n;
  logic          tick_act, accepted;
  logic [23:0]   disp_n;
  logic [2:0]    sel_mask_n;
  logic          mode_at_n;

`ifdef ALARM_CLOCK_EN
  logic [7:0] alarm_hour, alarm_min, alarm_hour_n, alarm_min_n;
  logic       match_n;
  logic       mode_bit;
  logic       match_q;
`endif

  // BCD hour increment in the configured 12/24 hour format
  function automatic logic [7:0] next_hour(input logic [7:0] h);
    logic [7:0] r;
    if (HOUR_24 != 0) begin
      if (h == 8'h23)            r = 8'h00;
      else if (h[3:0] == 4'd9)   r = {h[7:4] + 4'd1, 4'd0};
      else                       r = {h[7:4], h[3:0] + 4'd1};
    end else begin
      if (h == 8'h12)            r = 8'h01;
      else if (h[3:0] == 4'd9)   r = 8'h10;
      else                       r = {h[7:4], h[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD 00..59 increment with wrap
  function automatic logic [7:0] next_sixty(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)              r = 8'h00;
    else if (v[3:0] == 4'd9)     r = {v[7:4] + 4'd1, 4'd0};
    else                         r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Next state, time, alarm, blink and display values for this cycle
  always_comb begin
    state_n        = state;
    hour_n         = cur_hour;
    min_n          = cur_min;
    sec_n          = cur_sec;
    blink_cnt_n    = blink_cnt;
    blink_hidden_n = blink_hidden;
    accepted       = 1'b0;
    disp_n         = {hour_n, min_n, sec_n};
    sel_mask_n     = 3'b000;
    mode_at_n      = 1'b0;
`ifdef ALARM_CLOCK_EN
    alarm_hour_n   = alarm_hour;
    alarm_min_n    = alarm_min;
    match_n        = 1'b0;
`endif

    tick_act = tick_1hz && (state != SET_HOUR) && (state != SET_MIN) && (state != SET_SEC);
    if (tick_act) begin
      sec_n = next_sixty(cur_sec);
      if (cur_sec == 8'h59) begin
        min_n = next_sixty(cur_min);
        if (cur_min == 8'h59) hour_n = next_hour(cur_hour);
      end
    end
`ifdef ALARM_CLOCK_EN
    match_n = tick_act && (sec_n == 8'h00) && (hour_n == alarm_hour) && (min_n == alarm_min);
`endif

    if (btn_mode) begin
      accepted = 1'b1;
      case (state)
        RUN:                        state_n = SET_HOUR;
`ifdef ALARM_CLOCK_EN
        SET_HOUR, SET_MIN, SET_SEC: state_n = ALARM_HOUR;
`endif
        default:                    state_n = RUN;
      endcase
    end else if (btn_sel && state != RUN) begin
      accepted = 1'b1;
      case (state)
        SET_HOUR:   state_n = SET_MIN;
        SET_MIN:    state_n = SET_SEC;
        SET_SEC:    state_n = SET_HOUR;
`ifdef ALARM_CLOCK_EN
        ALARM_HOUR: state_n = ALARM_MIN;
        ALARM_MIN:  state_n = ALARM_HOUR;
`endif
        default:    state_n = state;
      endcase
    end else if (btn_inc && state != RUN) begin
      accepted = 1'b1;
      case (state)
        SET_HOUR:   hour_n = next_hour(cur_hour);
        SET_MIN:    min_n  = next_sixty(cur_min);
        SET_SEC:    sec_n  = 8'h00;
`ifdef ALARM_CLOCK_EN
        ALARM_HOUR: alarm_hour_n = next_hour(alarm_hour);
        ALARM_MIN:  alarm_min_n  = next_sixty(alarm_min);
`endif
        default:    sec_n = sec_n;
      endcase
    end

    if (accepted) begin
      blink_cnt_n    = '0;
      blink_hidden_n = 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt_n    = '0;
      blink_hidden_n = ~blink_hidden;
    end else begin
      blink_cnt_n    = blink_cnt + 1'b1;
    end

    case (state_n)
      SET_HOUR:   sel_mask_n = 3'b100;
      SET_MIN:    sel_mask_n = 3'b010;
      SET_SEC:    sel_mask_n = 3'b001;
`ifdef ALARM_CLOCK_EN
      ALARM_HOUR: sel_mask_n = 3'b100;
      ALARM_MIN:  sel_mask_n = 3'b010;
`endif
      default:    sel_mask_n = 3'b000;
    endcase

    disp_n = {hour_n, min_n, sec_n};
`ifdef ALARM_CLOCK_EN
    if (state_n == ALARM_HOUR || state_n == ALARM_MIN) begin
      disp_n    = {alarm_hour_n, alarm_min_n, 8'h00};
      mode_at_n = 1'b1;
    end
`endif
  end

  // State, time, blink and registered output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      cur_hour     <= HOUR_RESET;
      cur_min      <= 8'h00;
      cur_sec      <= 8'h00;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
      hour_first   <= HOUR_RESET[7:4];
      hour_second  <= HOUR_RESET[3:0];
      min_first    <= 4'd0;
      min_second   <= 4'd0;
      sec_first    <= 4'd0;
      sec_second   <= 4'd0;
      field_blank  <= 3'b000;
    end else begin
      state        <= state_n;
      cur_hour     <= hour_n;
      cur_min      <= min_n;
      cur_sec      <= sec_n;
      blink_cnt    <= blink_cnt_n;
      blink_hidden <= blink_hidden_n;
      hour_first   <= disp_n[23:20];
      hour_second  <= disp_n[19:16];
      min_first    <= disp_n[15:12];
      min_second   <= disp_n[11:8];
      sec_first    <= disp_n[7:4];
      sec_second   <= disp_n[3:0];
      field_blank  <= blink_hidden_n ? sel_mask_n : 3'b000;
    end
  end

`ifdef ALARM_CLOCK_EN
  // Alarm time registers plus the registered mode flag and match pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hour <= HOUR_RESET;
      alarm_min  <= 8'h00;
      mode_bit   <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      alarm_hour <= alarm_hour_n;
      alarm_min  <= alarm_min_n;
      mode_bit   <= mode_at_n;
      match_q    <= match_n;
    end
  end

  assign mode_at     = {3'b000, mode_bit};
  assign alarm_match = match_q;
`else
  assign mode_at     = {3'b000, mode_at_n & 1'b0};
  assign alarm_match = 1'b0;
`endif

endmodule
